// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared pipeline definitions for the decode/execute boundary:
//   - MIPS opcode constants for the supported instruction subset
//   - ALUop encodings produced by the main control unit
//   - ID/EX FSM state encoding
//   - packed EX-stage control bundle and the bubble value
//   - uses_rt(): whether an instruction reads rt as a source operand
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

    // rt is a true source when the ALU takes it as operand B (alusrc=0),
    // or when a store needs it as the write data (memwrite=1).
    function automatic logic uses_rt(input logic alusrc, input logic memwrite);
        return ~alusrc | memwrite;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector.
// Ports:
//   ex_memread_i  : instruction in EX is a load
//   ex_rt_i       : load destination register in EX
//   id_rs_i/rt_i  : source specifiers of the instruction in ID
//   id_alusrc_i   : ID instruction takes the immediate as ALU operand B
//   id_memwrite_i : ID instruction is a store (reads rt as data)
//   id_valid_i    : ID slot holds a legal instruction
//   run_i         : ID/EX FSM is in RUN (hazard is masked while stalled)
//   hazard_o      : load-use hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_alusrc_i,
    input  logic             id_memwrite_i,
    input  logic             id_valid_i,
    input  logic             run_i,
    output logic             hazard_o
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rt_i == id_rs_i);
        rt_match = (ex_rt_i == id_rt_i) & uses_rt(id_alusrc_i, id_memwrite_i);
        // A load into $zero never produces a dependency.
        hazard_o = ex_memread_i & (ex_rt_i != '0) & (rs_match | rt_match)
                 & id_valid_i & run_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall control and event counters.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : decode-stage control, fields and operands
//   flush               : branch taken, squash the decode slot
//   ex_*                : registered control/operands for EX
//   pc_write/ifid_write : PC and IF/ID may advance (low on a load-use hazard)
//   stalled             : FSM is in its single stall cycle
//   stall_count         : saturating count of stall entries
//   flush_count         : saturating count of flush edges
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_regdst,
    input  logic              id_branch,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic [1:0]        id_aluop,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dest,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              stalled,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e              state_q, state_d;
    ex_ctrl_t            ctrl_q, ctrl_d;
    logic                valid_q, valid_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic [REG_W-1:0]    rs_q, rt_q;
    logic [DATA_W-1:0]   rdata1_q, rdata2_q, imm_q, pc4_q;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic bubble;
    logic stall_enter;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ex_memread_i  (ctrl_q.memread),
        .ex_rt_i       (rt_q),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_alusrc_i   (id_alusrc),
        .id_memwrite_i (id_memwrite),
        .id_valid_i    (id_valid),
        .run_i         (state_q == ST_RUN),
        .hazard_o      (hazard)
    );

    always_comb begin
        bubble      = flush | hazard | ~id_valid;
        // Flush wins over a coincident hazard: the squashed instruction
        // no longer needs to wait for the load.
        stall_enter = hazard & ~flush;

        ctrl_d  = CTRL_BUBBLE;
        valid_d = 1'b0;
        dest_d  = '0;
        if (!bubble) begin
            ctrl_d.branch   = id_branch;
            ctrl_d.memread  = id_memread;
            ctrl_d.memtoreg = id_memtoreg;
            ctrl_d.memwrite = id_memwrite;
            ctrl_d.alusrc   = id_alusrc;
            ctrl_d.regwrite = id_regwrite;
            ctrl_d.aluop    = id_aluop;
            valid_d         = 1'b1;
            // Zeroing the destination of non-writing instructions hides the
            // don't-care RegDst of sw/beq from downstream forwarding.
            if (id_regwrite) begin
                dest_d = id_regdst ? id_rd : id_rt;
            end
        end

        // Hazard is masked in STALL, so STALL always returns to RUN.
        state_d = stall_enter ? ST_STALL : ST_RUN;

        stall_cnt_d = stall_cnt_q;
        if (stall_enter && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end

        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ctrl_q      <= CTRL_BUBBLE;
            valid_q     <= 1'b0;
            dest_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            dest_q      <= dest_d;
            // Operand fields are captured even for bubbles.
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rdata1_q    <= id_rdata1;
            rdata2_q    <= id_rdata2;
            imm_q       <= id_imm;
            pc4_q       <= id_pc4;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_branch   = ctrl_q.branch;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_valid    = valid_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dest     = dest_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;

    assign pc_write    = ~hazard;
    assign ifid_write  = ~hazard;
    assign stalled     = (state_q == ST_STALL);
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. A behavioural model tracks what EX must
// hold after every edge and is compared against the DUT each cycle; directed
// scenarios add hand-computed literal expectations. A second instance with
// 2-bit counters runs in lockstep to exercise counter saturation cheaply.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          id_valid = 0, id_regdst = 0, id_branch = 0, id_memread = 0;
    logic          id_memtoreg = 0, id_memwrite = 0, id_alusrc = 0, id_regwrite = 0;
    logic [1:0]    id_aluop = 0;
    logic [RW-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic [DW-1:0] id_rdata1 = 0, id_rdata2 = 0, id_imm = 0, id_pc4 = 0;
    logic          flush = 0;

    logic          ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]    ex_aluop;
    logic          ex_valid;
    logic [RW-1:0] ex_rs, ex_rt, ex_dest;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic          pc_write, ifid_write, stalled;
    logic [CW-1:0] stall_count, flush_count;

    // small-counter instance outputs
    logic          s_branch, s_memread, s_memtoreg, s_memwrite, s_alusrc, s_regwrite;
    logic [1:0]    s_aluop;
    logic          s_valid;
    logic [RW-1:0] s_rs, s_rt, s_dest;
    logic [DW-1:0] s_rdata1, s_rdata2, s_imm, s_pc4;
    logic          s_pc_write, s_ifid_write, s_stalled;
    logic [1:0]    s_stall_count, s_flush_count;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regdst(id_regdst),
        .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .pc_write(pc_write), .ifid_write(ifid_write), .stalled(stalled),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regdst(id_regdst),
        .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_branch(s_branch), .ex_memread(s_memread),
        .ex_memtoreg(s_memtoreg), .ex_memwrite(s_memwrite), .ex_alusrc(s_alusrc),
        .ex_regwrite(s_regwrite), .ex_aluop(s_aluop), .ex_valid(s_valid),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_dest(s_dest), .ex_rdata1(s_rdata1),
        .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .stalled(s_stalled),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what EX holds after each edge.
    // m_ctrl order: {branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop}
    // ------------------------------------------------------------------
    logic [7:0]    m_ctrl = 0;
    bit            m_valid = 0;
    logic [RW-1:0] m_rs = 0, m_rt = 0, m_dest = 0;
    logic [DW-1:0] m_r1 = 0, m_r2 = 0, m_imm = 0, m_pc4 = 0;
    bit            m_stalled = 0;
    int            m_stalls = 0, m_flushes = 0;

    task automatic m_reset();
        m_ctrl = 0; m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
        m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc4 = 0;
        m_stalled = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // A load in EX blocks an ID instruction that reads its destination.
    function automatic bit m_hazard();
        bit load_in_ex = m_ctrl[6];
        bit reads_rt   = !id_alusrc || id_memwrite;
        if (rst || !id_valid || m_stalled || !load_in_ex || m_rt == 0) return 0;
        return (m_rt == id_rs) || (reads_rt && m_rt == id_rt);
    endfunction

    task automatic m_step();
        bit hz, bub;
        if (rst) begin
            m_reset();
            return;
        end
        hz  = m_hazard();
        bub = flush || hz || !id_valid;
        if (flush && m_flushes < 65535) m_flushes++;
        if (hz && !flush && m_stalls < 65535) m_stalls++;
        m_stalled = hz && !flush;
        m_ctrl  = bub ? 8'h0 : {id_branch, id_memread, id_memtoreg, id_memwrite,
                                id_alusrc, id_regwrite, id_aluop};
        m_valid = !bub;
        m_dest  = (bub || !id_regwrite) ? '0 : (id_regdst ? id_rd : id_rt);
        m_rs = id_rs; m_rt = id_rt;
        m_r1 = id_rdata1; m_r2 = id_rdata2; m_imm = id_imm; m_pc4 = id_pc4;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Compare process: inputs change at negedge+1, checked at negedge+3,
    // model advances just after each rising edge.
    initial begin
        forever begin
            @(negedge clk); #3;
            if (rst) m_reset();
            chk("ctrl", {ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
                         ex_alusrc, ex_regwrite, ex_aluop}, m_ctrl);
            chk("ex_valid", ex_valid, m_valid);
            chk("ex_rs", ex_rs, m_rs);
            chk("ex_rt", ex_rt, m_rt);
            chk("ex_dest", ex_dest, m_dest);
            chk("ex_rdata1", ex_rdata1, m_r1);
            chk("ex_rdata2", ex_rdata2, m_r2);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_pc4", ex_pc4, m_pc4);
            chk("pc_write", pc_write, !m_hazard());
            chk("ifid_write", ifid_write, !m_hazard());
            chk("stalled", stalled, m_stalled);
            chk("stall_count", stall_count, m_stalls);
            chk("flush_count", flush_count, m_flushes);
            chk("sat_stall_count", s_stall_count, sat3(m_stalls));
            chk("sat_flush_count", s_flush_count, sat3(m_flushes));
            @(posedge clk); #1;
            m_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic drive(input logic [5:0] op, input int rs, input int rt, input int rd,
                         input bit valid = 1, input bit fl = 0);
        logic [8:0] c;
        // {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop}
        case (op)
            OP_RTYPE: c = {1'b1, 6'b000001, ALUOP_FUNCT};
            OP_LW:    c = {1'b0, 6'b011011, ALUOP_ADD};
            OP_SW:    c = {1'b1, 6'b000110, ALUOP_ADD}; // regdst is a don't-care
            default:  c = {1'b0, 6'b100000, ALUOP_SUB}; // beq
        endcase
        {id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
         id_alusrc, id_regwrite, id_aluop} = c;
        id_valid  = valid;
        flush     = fl;
        id_rs     = RW'(rs);
        id_rt     = RW'(rt);
        id_rd     = RW'(rd);
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
        id_imm    = $urandom;
        id_pc4    = id_pc4 + 32'd4;
    endtask

    logic [5:0] ops [4];

    initial begin
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;

        // Reset held
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_pc_write", pc_write, 1'b1);
        chk("rst_stall_count", stall_count, 16'd0);
        rst = 1'b0;

        // R-type add rs=1 rt=2 rd=3
        drive(OP_RTYPE, 1, 2, 3);
        tick();
        chk("rtype_regwrite", ex_regwrite, 1'b1);
        chk("rtype_aluop", ex_aluop, 2'b10);
        chk("rtype_dest", ex_dest, 5'd3);
        chk("rtype_valid", ex_valid, 1'b1);

        // Load-use: lw rt=5 then R-type rs=5
        drive(OP_LW, 1, 5, 0);
        tick();
        drive(OP_RTYPE, 5, 6, 7);
        #1 chk("lu_pc_write", pc_write, 1'b0);
        tick();
        chk("lu_bubble_valid", ex_valid, 1'b0);
        chk("lu_stalled", stalled, 1'b1);
        chk("lu_stall_count", stall_count, 16'd1);
        #1 chk("lu_pc_write_masked", pc_write, 1'b1);
        tick();
        chk("lu_capture_valid", ex_valid, 1'b1);
        chk("lu_capture_dest", ex_dest, 5'd7);
        chk("lu_unstalled", stalled, 1'b0);

        // lw rt=5 then lw rs=2 rt=5: rt is not a source
        drive(OP_LW, 1, 5, 0);
        tick();
        drive(OP_LW, 2, 5, 0);
        #1 chk("lwlw_pc_write", pc_write, 1'b1);
        // lw rt=0 then rs=0: $zero never stalls
        tick();
        drive(OP_LW, 1, 0, 0);
        tick();
        drive(OP_RTYPE, 0, 0, 4);
        #1 chk("zero_pc_write", pc_write, 1'b1);

        // Flush coincident with hazard
        tick();
        drive(OP_LW, 0, 5, 0);
        tick();
        drive(OP_RTYPE, 5, 6, 7, 1, 1);
        #1 chk("fl_pc_write", pc_write, 1'b0);
        tick();
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_regwrite", ex_regwrite, 1'b0);
        chk("fl_stalled", stalled, 1'b0);
        chk("fl_flush_count", flush_count, 16'd1);
        chk("fl_stall_count", stall_count, 16'd1);

        // sw with regdst=1 and a nonzero rd
        drive(OP_SW, 3, 4, 9);
        tick();
        chk("sw_dest", ex_dest, 5'd0);
        chk("sw_memwrite", ex_memwrite, 1'b1);
        chk("sw_regwrite", ex_regwrite, 1'b0);

        // beq, then an invalid slot
        drive(OP_BEQ, 1, 2, 0);
        tick();
        chk("beq_aluop", ex_aluop, 2'b01);
        drive(OP_RTYPE, 1, 2, 3, 0);
        tick();
        chk("inv_valid", ex_valid, 1'b0);

        // Four more stalls: 16-bit counter reaches 5, 2-bit counter stays at 3
        for (int i = 0; i < 4; i++) begin
            drive(OP_LW, 0, 8, 0);
            tick();
            drive(OP_RTYPE, 8, 1, 2);
            tick();
            tick();
        end
        chk("stall_count_5", stall_count, 16'd5);
        chk("sat_stall_hold", s_stall_count, 2'd3);

        // Four more flushes: 16-bit counter 5, 2-bit counter saturated
        for (int i = 0; i < 4; i++) begin
            drive(OP_BEQ, 1, 2, 0, 1, 1);
            tick();
        end
        chk("flush_count_5", flush_count, 16'd5);
        chk("sat_flush_hold", s_flush_count, 2'd3);

        // Reset in the middle of a stall
        drive(OP_LW, 1, 5, 0);
        tick();
        drive(OP_RTYPE, 5, 6, 7);
        tick();
        chk("mid_stalled_pre", stalled, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stalled", stalled, 1'b0);
        chk("mid_rst_valid", ex_valid, 1'b0);
        chk("mid_rst_stall_count", stall_count, 16'd0);
        chk("mid_rst_flush_count", flush_count, 16'd0);
        chk("mid_rst_pc_write", pc_write, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", ex_valid, 1'b1);
        chk("post_rst_dest", ex_dest, 5'd7);

        // Mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            drive(ops[$urandom_range(0, 3)], $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 5) == 0));
            tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width of register operands, immediate and PC.
REQ-002 Parameter REG_W, 5, register-specifier width.
REQ-003 Parameter CNT_W, 16, width of the stall and flush event counters.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 id_valid in 1: decode slot holds a legal instruction (R_type/lw/sw/beq); id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite in 1 each; id_aluop in 2: control-unit outputs.
REQ-006 id_rs, id_rt, id_rd in REG_W; id_rdata1, id_rdata2, id_imm, id_pc4 in DATA_W: decoded fields, register-file reads, sign-extended immediate, PC+4.
REQ-007 flush in 1: branch taken, squash the decode slot.
REQ-008 ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite out 1; ex_aluop out 2; ex_valid out 1: registered control.
REQ-009 ex_rs, ex_rt, ex_dest out REG_W; ex_rdata1, ex_rdata2, ex_imm, ex_pc4 out DATA_W: registered operands.
REQ-010 pc_write, ifid_write out 1 (combinational): allow PC and IF/ID to advance; stalled out 1: FSM in STALL.
REQ-011 stall_count, flush_count out CNT_W: saturating event counters.

Function
REQ-012 hazard SHALL be combinational: ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt & uses_rt)) & id_valid & state==RUN, where uses_rt = ~id_alusrc | id_memwrite.
REQ-013 pc_write and ifid_write SHALL both equal ~hazard.
REQ-014 Capture priority each rising edge: flush, then hazard, then ~id_valid (all three insert a bubble), else normal capture.
REQ-015 Bubble SHALL drive all ex_ control bits, ex_aluop and ex_valid to 0 and ex_dest to 0; data fields are captured from inputs unchanged.
REQ-016 Normal capture SHALL register all id_ fields with latency exactly one cycle and set ex_valid=1.
REQ-017 ex_dest SHALL be id_rd when id_regdst=1, else id_rt, forced to 0 when id_regwrite=0 (removes don't-care RegDst of sw/beq).
REQ-018 FSM states RUN, STALL; RUN->STALL on hazard & ~flush; STALL->RUN unconditionally next cycle; hazard is masked in STALL, so at most one consecutive stall cycle.
REQ-019 flush coincident with hazard: flush wins, no STALL entry, pc_write=0 still reported that cycle per REQ-013, flush_count increments, stall_count does not.
REQ-020 stall_count SHALL increment on each RUN->STALL transition; flush_count on each edge with flush=1; both saturate at 2^CNT_W-1, no wrap.
REQ-021 stalled SHALL be 1 exactly while state==STALL.

Reset
REQ-022 rst SHALL asynchronously force state=RUN, all ex_ outputs 0, ex_valid 0, both counters 0; pc_write=ifid_write=1 while rst held.
REQ-023 rst asserted mid-stall SHALL abandon the stall; first edge after release performs normal capture.

Structure
REQ-024 Opcode constants (R_type 000000, lw 100011, sw 101011, beq 000100), ALUop encodings (00 add, 01 sub, 10 funct) and FSM state encoding SHALL live in the shared pipeline package.
REQ-025 Hazard comparison SHALL be a sub-module hazard_detect (pure combinational); register, FSM and counters stay in id_ex_stage.

Verification
REQ-026 R_type add, rs=1, rt=2, rd=3, id_valid=1 -> next cycle ex_regwrite=1, ex_aluop=10, ex_dest=3, ex_valid=1.
REQ-027 lw rt=5 in EX, R_type rs=5 in ID -> hazard, pc_write=0 one cycle, bubble (ex_valid=0), stalled=1 one cycle, stall_count=1, then R_type captured.
REQ-028 lw rt=5 in EX, lw rs=2 rt=5 in ID -> no hazard (uses_rt=0); lw rt=0 in EX, rs=0 in ID -> no hazard.
REQ-029 flush=1 with simultaneous hazard -> ex_ control all 0, stalled=0, flush_count=1, stall_count=0.
REQ-030 sw with id_regdst=X -> ex_dest=0, ex_memwrite=1, ex_regwrite=0; force stall_count to 16'hFFFF, cause another stall -> stays 16'hFFFF.
REQ-031 rst pulsed during STALL -> outputs zero immediately, stalled=0, counters 0.
